operand_loader: RTL and testbench

Upstream stage of the 5-bit ALU datapath: it turns raw board switches and push-buttons into the two registered operands and the select line consumed by the value mux. Each button is synchronised, debounced and edge-detected. A small state machine then captures the switch value first into operand A, then into operand B. A `valid` flag tells downstream logic when a complete operand pair is held.

---
 rtl/alu_pkg.sv | 14 +
 rtl/button_conditioner.sv | 50 +++++
 rtl/operand_loader.sv | 126 ++++++++++++
 tb/tb_operand_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 5-bit ALU datapath.
//   OPERAND_WIDTH  : datapath width shared by the loader and the value mux
//   loader_state_t : operand loader FSM encoding (also shown on the debug LEDs)
package alu_pkg;

   localparam int OPERAND_WIDTH = 5;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HAVE_A = 2'd1,
      READY  = 2'd2
   } loader_state_t;

endpackage : alu_pkg

// File: rtl/button_conditioner.sv
// Turns one raw, bouncing, asynchronous push-button into a clean level and a
// single-cycle press pulse.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   btn_raw     : raw button input, active-high, asynchronous
//   level       : debounced button level
//   press_pulse : one-cycle pulse on each accepted 0->1 transition of level
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          pulse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         pulse_q <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            // Sample has disagreed for DEBOUNCE_CYCLES counts: accept it.
            level_q <= sync_q[1];
            cnt_q   <= '0;
            pulse_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level       = level_q;
   assign press_pulse = pulse_q;

endmodule : button_conditioner

// File: rtl/operand_loader.sv
// Operand loader: captures the switch value into operand A then operand B on
// successive debounced load presses, toggles the mux select on sel presses and
// clears everything on clear presses.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   sw                             : raw switches, sampled only on a capture edge
//   btn_load, btn_sel, btn_clear   : raw push-buttons, active-high
//   operand_a, operand_b           : registered operands to mux Input0/Input1
//   sel                            : registered mux select (0 -> A, 1 -> B)
//   valid                          : high while a full pair is held (state READY)
//   state                          : FSM state for LEDs/debug
//
// state  | meaning
// EMPTY  | no operand held
// HAVE_A | operand A captured, waiting for B
// READY  | both operands held, valid=1
// 2'd3   | unreachable, recovers to EMPTY
module operand_loader
   import alu_pkg::*;
#(
   parameter int WIDTH           = OPERAND_WIDTH,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn_load,
   input  logic             btn_sel,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             sel,
   output logic             valid,
   output logic [1:0]       state
);

   logic          load_p;
   logic          sel_p;
   logic          clr_p;
   logic [2:0]    unused_level;

   loader_state_t    state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sel_q;
   logic             valid_q;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_load (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_load),
      .level       (unused_level[0]),
      .press_pulse (load_p)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sel (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_sel),
      .level       (unused_level[1]),
      .press_pulse (sel_p)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_clear),
      .level       (unused_level[2]),
      .press_pulse (clr_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (clr_p) begin
         // Clear wins over any load or sel pulse in the same cycle.
         state_q <= EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         if (sel_p) begin
            sel_q <= ~sel_q;
         end
         case (state_q)
            EMPTY: begin
               if (load_p) begin
                  a_q     <= sw;
                  state_q <= HAVE_A;
               end
            end
            HAVE_A: begin
               if (load_p) begin
                  b_q     <= sw;
                  valid_q <= 1'b1;
                  state_q <= READY;
               end
            end
            READY: begin
               // A load from READY starts a fresh pair.
               if (load_p) begin
                  a_q     <= sw;
                  b_q     <= '0;
                  valid_q <= 1'b0;
                  state_q <= HAVE_A;
               end
            end
            default: begin
               state_q <= EMPTY;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign operand_a = a_q;
   assign operand_b = b_q;
   assign sel       = sel_q;
   assign valid     = valid_q;
   assign state     = state_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

   logic       clk;
   logic       rst_n;
   logic [4:0] sw;
   logic       btn_load;
   logic       btn_sel;
   logic       btn_clear;
   logic [4:0] operand_a;
   logic [4:0] operand_b;
   logic       sel;
   logic       valid;
   logic [1:0] state;

   int n_chk = 0;
   int n_bad = 0;

   operand_loader #(.WIDTH(5), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .btn_load  (btn_load),
      .btn_sel   (btn_sel),
      .btn_clear (btn_clear),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .sel       (sel),
      .valid     (valid),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic s, input logic v, input logic [1:0] st);
      chk({tag, ".a"},     {27'd0, operand_a}, {27'd0, a});
      chk({tag, ".b"},     {27'd0, operand_b}, {27'd0, b});
      chk({tag, ".sel"},   {31'd0, sel},       {31'd0, s});
      chk({tag, ".valid"}, {31'd0, valid},     {31'd0, v});
      chk({tag, ".state"}, {30'd0, state},     {30'd0, st});
   endtask

   initial begin
      rst_n = 1'b0; sw = '0; btn_load = 0; btn_sel = 0; btn_clear = 0;
      tick(3);
      chk_all("reset0", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b1;
      tick(3);

      // Load A = 9, exact latency: unchanged after 7 edges, captured on the 8th.
      sw = 5'd9; btn_load = 1;
      tick(7);
      chk_all("loadA_early", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
      tick(1);
      chk_all("loadA", 5'd9, 5'd0, 1'b0, 1'b0, 2'd1);
      btn_load = 0; tick(10);

      // Load B = 22.
      sw = 5'd22; btn_load = 1;
      tick(7);
      chk("loadB_early.b", {27'd0, operand_b}, 32'd0);
      tick(1);
      chk_all("loadB", 5'd9, 5'd22, 1'b0, 1'b1, 2'd2);
      btn_load = 0; tick(10);

      // Bounce: high/low every 2 cycles for 20 cycles.
      sw = 5'd7;
      for (int i = 0; i < 5; i++) begin
         btn_load = 1; tick(2);
         btn_load = 0; tick(2);
      end
      tick(10);
      chk_all("bounce", 5'd9, 5'd22, 1'b0, 1'b1, 2'd2);

      // 3-cycle glitch.
      btn_load = 1; tick(3); btn_load = 0; tick(10);
      chk_all("glitch", 5'd9, 5'd22, 1'b0, 1'b1, 2'd2);

      // Re-load from READY.
      sw = 5'd3; btn_load = 1; tick(8);
      chk_all("reload", 5'd3, 5'd0, 1'b0, 1'b0, 2'd1);
      btn_load = 0; tick(10);

      // Sel press toggles sel only.
      btn_sel = 1; tick(7);
      chk("sel_early", {31'd0, sel}, 32'd0);
      tick(1);
      chk_all("sel", 5'd3, 5'd0, 1'b1, 1'b0, 2'd1);
      btn_sel = 0; tick(10);

      // Sel and load together: both take effect.
      sw = 5'd17; btn_sel = 1; btn_load = 1; tick(8);
      chk_all("sel_load", 5'd3, 5'd17, 1'b0, 1'b1, 2'd2);
      btn_sel = 0; btn_load = 0; tick(10);

      // Make sel=1 again, then clear and load together: clear wins.
      btn_sel = 1; tick(8);
      chk("sel2", {31'd0, sel}, 32'd1);
      btn_sel = 0; tick(10);
      sw = 5'd5; btn_clear = 1; btn_load = 1; tick(8);
      chk_all("clr_load", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
      btn_clear = 0; btn_load = 0; tick(10);

      // Hold load 50 cycles: exactly one capture, even with sw changing.
      sw = 5'd12; btn_load = 1; tick(20);
      sw = 5'd20; tick(30);
      btn_load = 0; tick(10);
      chk_all("hold", 5'd12, 5'd0, 1'b0, 1'b0, 2'd1);

      // Clear, then load 0x1F, then async reset between clock edges.
      btn_clear = 1; tick(8);
      chk_all("clear", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
      btn_clear = 0; tick(10);
      sw = 5'h1F; btn_load = 1; tick(8);
      chk("pre_rst.a", {27'd0, operand_a}, 32'h1F);
      btn_load = 0; tick(10);
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_operand_loader
